// File: rtl/sbox_scheduler.sv
// Shares one combinational S-box between the state data path (16 bytes) and the
// key schedule (4 bytes). Jobs are processed one byte per clock, with key-schedule jobs taking priority.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no byte in flight; arbitrates pending jobs (ks first)
// KS    | streaming key-schedule word bytes through the S-box, fwd mode
// ST    | streaming state bytes through the S-box, latched direction
module sbox_scheduler #(
    parameter int ST_BYTES = 16,
    parameter int KS_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  st_start,
    input  logic                  st_mode,
    input  logic [8*ST_BYTES-1:0] st_in,
    output logic [8*ST_BYTES-1:0] st_out,
    output logic                  st_done,
    input  logic                  ks_start,
    input  logic [8*KS_BYTES-1:0] ks_in,
    output logic [8*KS_BYTES-1:0] ks_out,
    output logic                  ks_done,
    output logic                  busy,
    output logic [7:0]            sb_a,
    output logic                  sb_mode,
    input  logic [7:0]            sb_z
);

    localparam int CW = $clog2(ST_BYTES);
    localparam int KW = $clog2(KS_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KS   = 2'd1,
        ST   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          ks_pend;
    logic          st_pend;
    logic          st_mode_q;
    logic          ks_last;
    logic          st_last;

    logic [7:0] st_byte [ST_BYTES];
    logic [7:0] st_res  [ST_BYTES];
    logic [7:0] ks_byte [KS_BYTES];
    logic [7:0] ks_res  [KS_BYTES];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sb_a      = '0;
        sb_mode   = 1'b1;
        ks_last   = 1'b0;
        st_last   = 1'b0;
        case (state)
            IDLE: begin
                if (ks_pend) begin
                    state_nxt = KS;
                end else if (st_pend) begin
                    state_nxt = ST;
                end
            end
            KS: begin
                sb_a = ks_byte[cnt[KW-1:0]];
                if (cnt == CW'(KS_BYTES - 1)) begin
                    ks_last   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            ST: begin
                sb_a    = st_byte[cnt];
                sb_mode = st_mode_q;
                if (cnt == CW'(ST_BYTES - 1)) begin
                    st_last   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pending flags stay set through the last byte, so a start arriving while the
    // channel is still busy is dropped rather than overwriting in-flight data.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            ks_pend   <= 1'b0;
            st_pend   <= 1'b0;
            st_mode_q <= 1'b1;
            ks_done   <= 1'b0;
            st_done   <= 1'b0;
            for (int i = 0; i < ST_BYTES; i++) begin
                st_byte[i] <= '0;
                st_res[i]  <= '0;
            end
            for (int i = 0; i < KS_BYTES; i++) begin
                ks_byte[i] <= '0;
                ks_res[i]  <= '0;
            end
        end else begin
            ks_done <= ks_last;
            st_done <= st_last;
            cnt     <= (state == IDLE || ks_last || st_last) ? '0 : cnt + 1'b1;

            if (state == KS) begin
                ks_res[cnt[KW-1:0]] <= sb_z;
            end
            if (state == ST) begin
                st_res[cnt] <= sb_z;
            end

            if (ks_start && !ks_pend) begin
                ks_pend <= 1'b1;
                for (int i = 0; i < KS_BYTES; i++) begin
                    ks_byte[i] <= ks_in[8*(KS_BYTES-1-i) +: 8];
                end
            end else if (ks_last) begin
                ks_pend <= 1'b0;
            end

            if (st_start && !st_pend) begin
                st_pend   <= 1'b1;
                st_mode_q <= st_mode;
                for (int i = 0; i < ST_BYTES; i++) begin
                    st_byte[i] <= st_in[8*(ST_BYTES-1-i) +: 8];
                end
            end else if (st_last) begin
                st_pend <= 1'b0;
            end
        end
    end

    // Byte 0 sits in the most significant lane.
    always_comb begin
        st_out = '0;
        for (int i = 0; i < ST_BYTES; i++) begin
            st_out[8*(ST_BYTES-1-i) +: 8] = st_res[i];
        end
    end

    always_comb begin
        ks_out = '0;
        for (int i = 0; i < KS_BYTES; i++) begin
            ks_out[8*(KS_BYTES-1-i) +: 8] = ks_res[i];
        end
    end

    assign busy = ks_pend | st_pend | (state != IDLE);

endmodule

// File: tb/tb_sbox_scheduler.sv
// Bench for sbox_scheduler: an AES S-box derived from GF(2^8) arithmetic, a
// job-level reference model, directed literal scenarios and random traffic.
module tb_sbox_scheduler;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         st_start = 1'b0;
    logic         st_mode = 1'b1;
    logic [127:0] st_in = '0;
    logic [127:0] st_out;
    logic         st_done;
    logic         ks_start = 1'b0;
    logic [31:0]  ks_in = '0;
    logic [31:0]  ks_out;
    logic         ks_done;
    logic         busy;
    logic [7:0]   sb_a;
    logic         sb_mode;
    logic [7:0]   sb_z;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    localparam logic [127:0] V0 = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] R0 = 128'h638293c3_1bfc33f5_c4eeacea_4bc12816;

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    assign sb_z = sb_mode ? fwd_tab[sb_a] : inv_tab[sb_a];

    sbox_scheduler dut (
        .clk      (clk),
        .rst      (rst),
        .st_start (st_start),
        .st_mode  (st_mode),
        .st_in    (st_in),
        .st_out   (st_out),
        .st_done  (st_done),
        .ks_start (ks_start),
        .ks_in    (ks_in),
        .ks_out   (ks_out),
        .ks_done  (ks_done),
        .busy     (busy),
        .sb_a     (sb_a),
        .sb_mode  (sb_mode),
        .sb_z     (sb_z)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- S-box from field arithmetic ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] x);
        for (int j = 1; j < 256; j++) begin
            if (gmul(x, 8'(j)) == 8'h01) return 8'(j);
        end
        return 8'h00;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbx(input logic [7:0] b, input logic fwd);
        return fwd ? fwd_tab[b] : inv_tab[b];
    endfunction

    function automatic logic [127:0] sub_state(input logic [127:0] s, input logic fwd);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sbx(s[8*i +: 8], fwd);
        return r;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = sbx(w[8*i +: 8], 1'b1);
        return r;
    endfunction

    function automatic logic [7:0] state_byte(input logic [127:0] s, input int i);
        logic [127:0] t;
        t = s << (8 * i);
        return t[127:120];
    endfunction

    function automatic logic [7:0] word_byte(input logic [31:0] w, input int i);
        logic [31:0] t;
        t = w << (8 * i);
        return t[31:24];
    endfunction

    // ---------------- job-level reference model ----------------
    // m_job: 0 none, 1 key-schedule word, 2 state; m_idx: byte being substituted.
    logic         m_live = 1'b0;
    logic         m_ks_pend, m_st_pend, m_st_mode;
    logic [31:0]  m_ks_data, m_ks_exp;
    logic [127:0] m_st_data, m_st_exp;
    logic         m_ks_done, m_st_done, m_ks_valid, m_st_valid;
    int           m_job, m_idx;

    always @(posedge clk) begin : model
        int           job, idx;
        logic         ksp, stp, ksv, stv, kd, sd;
        logic [31:0]  kse;
        logic [127:0] ste;
        if (rst) begin
            m_live     <= 1'b1;
            m_ks_pend  <= 1'b0;
            m_st_pend  <= 1'b0;
            m_st_mode  <= 1'b1;
            m_ks_data  <= '0;
            m_st_data  <= '0;
            m_ks_exp   <= '0;
            m_st_exp   <= '0;
            m_ks_done  <= 1'b0;
            m_st_done  <= 1'b0;
            m_ks_valid <= 1'b1;
            m_st_valid <= 1'b1;
            m_job      <= 0;
            m_idx      <= 0;
        end else if (m_live) begin
            job = m_job; idx = m_idx;
            ksp = m_ks_pend; stp = m_st_pend;
            ksv = m_ks_valid; stv = m_st_valid;
            kse = m_ks_exp; ste = m_st_exp;
            kd = 1'b0; sd = 1'b0;
            if (job == 0) begin
                if (ksp) begin
                    job = 1; idx = 0; ksv = 1'b0;
                end else if (stp) begin
                    job = 2; idx = 0; stv = 1'b0;
                end
            end else if (idx == ((job == 1) ? 3 : 15)) begin
                if (job == 1) begin
                    ksp = 1'b0; kd = 1'b1; kse = sub_word(m_ks_data); ksv = 1'b1;
                end else begin
                    stp = 1'b0; sd = 1'b1; ste = sub_state(m_st_data, m_st_mode); stv = 1'b1;
                end
                job = 0; idx = 0;
            end else begin
                idx = idx + 1;
            end
            if (ks_start && !m_ks_pend) begin
                ksp = 1'b1;
                m_ks_data <= ks_in;
            end
            if (st_start && !m_st_pend) begin
                stp = 1'b1;
                m_st_data <= st_in;
                m_st_mode <= st_mode;
            end
            m_job      <= job;
            m_idx      <= idx;
            m_ks_pend  <= ksp;
            m_st_pend  <= stp;
            m_ks_valid <= ksv;
            m_st_valid <= stv;
            m_ks_exp   <= kse;
            m_st_exp   <= ste;
            m_ks_done  <= kd;
            m_st_done  <= sd;
        end
    end

    always @(negedge clk) begin
        logic [7:0] exp_a;
        if (m_live) begin
            exp_a = (m_job == 1) ? word_byte(m_ks_data, m_idx) :
                    (m_job == 2) ? state_byte(m_st_data, m_idx) : 8'h00;
            chk("m_busy", 128'(busy), 128'(m_ks_pend | m_st_pend | (m_job != 0)));
            chk("m_ks_done", 128'(ks_done), 128'(m_ks_done));
            chk("m_st_done", 128'(st_done), 128'(m_st_done));
            chk("m_sb_mode", 128'(sb_mode), 128'((m_job == 2) ? m_st_mode : 1'b1));
            chk("m_sb_a", 128'(sb_a), 128'(exp_a));
            if (m_ks_valid) chk("m_ks_out", 128'(ks_out), 128'(m_ks_exp));
            if (m_st_valid) chk("m_st_out", st_out, m_st_exp);
        end
    end

    // ---------------- directed observation window ----------------
    logic         w_ks_d [64];
    logic         w_st_d [64];
    logic         w_busy [64];
    logic         w_sbm  [64];
    logic [7:0]   w_sba  [64];
    logic [31:0]  w_ks_out [64];
    logic [127:0] w_st_out [64];

    // Caller drives cycle-0 inputs just after a rising edge, then calls this.
    task automatic run_window(input int n, input int restart_at, input logic [127:0] restart_data,
                              input int rst_at);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            w_ks_d[k]   = ks_done;
            w_st_d[k]   = st_done;
            w_busy[k]   = busy;
            w_sbm[k]    = sb_mode;
            w_sba[k]    = sb_a;
            w_ks_out[k] = ks_out;
            w_st_out[k] = st_out;
            @(posedge clk);
            #1;
            ks_start = 1'b0;
            st_start = 1'b0;
            rst      = 1'b0;
            if (k + 1 == restart_at) begin
                st_start = 1'b1;
                st_in    = restart_data;
            end
            if (k + 1 == rst_at) rst = 1'b1;
        end
    endtask

    function automatic int first_hit(input logic a [64], input int n);
        for (int k = 0; k < n; k++) if (a[k]) return k;
        return -1;
    endfunction

    function automatic int count_val(input logic a [64], input int n, input logic v);
        int c;
        c = 0;
        for (int k = 0; k < n; k++) if (a[k] == v) c++;
        return c;
    endfunction

    task automatic go;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] f;
        for (int x = 0; x < 256; x++) begin
            f = affine(ginv(8'(x)));
            fwd_tab[x] = f;
            inv_tab[f] = 8'(x);
        end

        repeat (3) go();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_st_out", st_out, '0);
        chk("rst_ks_out", 128'(ks_out), '0);
        chk("rst_busy", 128'(busy), '0);
        chk("rst_sb_a", 128'(sb_a), '0);
        chk("rst_sb_mode", 128'(sb_mode), 128'(1));
        chk("rst_done", 128'({st_done, ks_done}), '0);

        go(); st_start = 1'b1; st_mode = 1'b1; st_in = V0;
        run_window(30, -1, '0, -1);
        chk("fwd_done_cycle", 128'(first_hit(w_st_d, 30)), 128'(18));
        chk("fwd_done_count", 128'(count_val(w_st_d, 30, 1'b1)), 128'(1));
        chk("fwd_st_out", w_st_out[18], R0);

        go(); st_start = 1'b1; st_mode = 1'b0; st_in = R0;
        run_window(30, -1, '0, -1);
        chk("inv_done_cycle", 128'(first_hit(w_st_d, 30)), 128'(18));
        chk("inv_st_out", w_st_out[18], V0);
        chk("inv_sbmode_low_cycles", 128'(count_val(w_sbm, 30, 1'b0)), 128'(16));

        go(); ks_start = 1'b1; ks_in = 32'hcf4f3c09;
        run_window(20, -1, '0, -1);
        chk("ks_done_cycle", 128'(first_hit(w_ks_d, 20)), 128'(6));
        chk("ks_out", 128'(w_ks_out[6]), 128'(32'h8a84eb01));
        chk("ks_sbmode_fwd", 128'(count_val(w_sbm, 20, 1'b1)), 128'(20));

        go(); ks_start = 1'b1; ks_in = 32'h09cf4f3c; st_start = 1'b1; st_mode = 1'b1; st_in = V0;
        run_window(30, -1, '0, -1);
        chk("both_ks_cycle", 128'(first_hit(w_ks_d, 30)), 128'(6));
        chk("both_st_cycle", 128'(first_hit(w_st_d, 30)), 128'(23));
        chk("both_ks_out", 128'(w_ks_out[6]), 128'(32'h018a84eb));
        chk("both_st_out", w_st_out[23], R0);
        chk("both_busy_count", 128'(count_val(w_busy, 30, 1'b1)), 128'(22));
        chk("both_busy_c1", 128'(w_busy[1]), 128'(1));
        chk("both_busy_c22", 128'(w_busy[22]), 128'(1));
        chk("both_busy_c23", 128'(w_busy[23]), 128'(0));

        go(); st_start = 1'b1; st_mode = 1'b0; st_in = R0;
        run_window(40, 5, V0 ^ 128'h5a, -1);
        chk("second_start_done_count", 128'(count_val(w_st_d, 40, 1'b1)), 128'(1));
        chk("second_start_done_cycle", 128'(first_hit(w_st_d, 40)), 128'(18));
        chk("second_start_out", w_st_out[18], V0);
        chk("second_start_hold", w_st_out[39], V0);

        go(); st_start = 1'b1; st_mode = 1'b1; st_in = V0;
        run_window(30, -1, '0, 9);
        chk("rst_mid_byte7", 128'(w_sba[9]), 128'(8'h77));
        chk("rst_mid_st_out", w_st_out[10], '0);
        chk("rst_mid_ks_out", 128'(w_ks_out[10]), '0);
        chk("rst_mid_busy", 128'(w_busy[10]), '0);
        chk("rst_mid_sb_a", 128'(w_sba[10]), '0);
        chk("rst_mid_sb_mode", 128'(w_sbm[10]), 128'(1));
        chk("rst_mid_no_done", 128'(count_val(w_st_d, 30, 1'b1)), '0);

        go(); st_start = 1'b1; st_mode = 1'b1; st_in = V0;
        run_window(30, -1, '0, -1);
        chk("after_rst_done_cycle", 128'(first_hit(w_st_d, 30)), 128'(18));
        chk("after_rst_st_out", w_st_out[18], R0);

        for (int c = 0; c < 3000; c++) begin
            go();
            ks_start = ($urandom_range(0, 5) == 0);
            st_start = ($urandom_range(0, 7) == 0);
            st_mode  = 1'($urandom_range(0, 1));
            ks_in    = $urandom;
            st_in    = {$urandom, $urandom, $urandom, $urandom};
            rst      = ($urandom_range(0, 399) == 0);
        end
        go();
        ks_start = 1'b0;
        st_start = 1'b0;
        rst      = 1'b0;
        repeat (40) go();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
